// File: rtl/reg_wr_sched_if.sv
// reg_wr_sched_if: write-request, register-file write, read-forward and status bundle for reg_wr_sched_fpga
interface reg_wr_sched_if #(parameter int QDEPTH = 4, parameter int ADDR_W = 7, parameter int DATA_W = 32);
  localparam int CW = $clog2(QDEPTH) + 1;
  logic wr0_en;
  logic [ADDR_W-1:0] wr0_addr;
  logic [DATA_W-1:0] wr0_data;
  logic wr1_en;
  logic [ADDR_W-1:0] wr1_addr;
  logic [DATA_W-1:0] wr1_data;
  logic wr_stall;
  logic rf_wr_en;
  logic [ADDR_W-1:0] rf_wr_addr;
  logic [DATA_W-1:0] rf_wr_data;
  logic [2:0][ADDR_W-1:0] rd_addr;
  logic [2:0] rd_fwd_en;
  logic [2:0][DATA_W-1:0] rd_fwd_data;
  logic [CW-1:0] q_count;
  logic ovf_err;
  modport master(output wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data, rd_addr,
                 input wr_stall, rf_wr_en, rf_wr_addr, rf_wr_data, rd_fwd_en, rd_fwd_data, q_count, ovf_err);
  modport slave(input wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data, rd_addr,
                output wr_stall, rf_wr_en, rf_wr_addr, rf_wr_data, rd_fwd_en, rd_fwd_data, q_count, ovf_err);
endinterface

// File: rtl/reg_wr_sched_fpga.sv
// reg_wr_sched_fpga: serialises up to two writes per cycle onto one register-file write port and forwards pending data to three reads
module reg_wr_sched_fpga #(parameter int QDEPTH = 4, parameter int ADDR_W = 7, parameter int DATA_W = 32) (
  input logic clk,
  input logic rst,
  reg_wr_sched_if.slave bus
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  logic [ADDR_W-1:0] q_addr [QDEPTH];
  logic [DATA_W-1:0] q_data [QDEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] q_count, n_push;
  logic acc0, acc1, pop, ld_en;
  logic [ADDR_W-1:0] ld_addr, p0_addr;
  logic [DATA_W-1:0] ld_data, p0_data;
  logic [2:0] fwd_en;
  logic [2:0][DATA_W-1:0] fwd_data;
  assign bus.wr_stall = q_count >= CW'(QDEPTH - 1);
  assign bus.q_count = q_count;
  assign acc0 = bus.wr0_en & ~bus.wr_stall;
  assign acc1 = bus.wr1_en & ~bus.wr_stall;
  assign pop = q_count != '0;
  // The queue head always wins the write port; inputs only bypass an empty queue.
  always_comb begin
    ld_en = pop | acc0 | acc1;
    ld_addr = pop ? q_addr[head] : acc0 ? bus.wr0_addr : bus.wr1_addr;
    ld_data = pop ? q_data[head] : acc0 ? bus.wr0_data : bus.wr1_data;
    n_push = pop ? CW'(acc0) + CW'(acc1) : CW'(acc0 & acc1);
    p0_addr = (pop & acc0) ? bus.wr0_addr : bus.wr1_addr;
    p0_data = (pop & acc0) ? bus.wr0_data : bus.wr1_data;
  end
  // Sources are scanned oldest-first so the youngest match overwrites earlier ones.
  always_comb begin
    fwd_en = '0;
    fwd_data = '0;
    for (int r = 0; r < 3; r++) begin
      if (bus.rf_wr_en && bus.rf_wr_addr == bus.rd_addr[r]) begin
        fwd_en[r] = 1'b1;
        fwd_data[r] = bus.rf_wr_data;
      end
      for (int i = 0; i < QDEPTH; i++)
        if (CW'(i) < q_count && q_addr[head + PW'(i)] == bus.rd_addr[r]) begin
          fwd_en[r] = 1'b1;
          fwd_data[r] = q_data[head + PW'(i)];
        end
      if (acc0 && bus.wr0_addr == bus.rd_addr[r]) begin
        fwd_en[r] = 1'b1;
        fwd_data[r] = bus.wr0_data;
      end
      if (acc1 && bus.wr1_addr == bus.rd_addr[r]) begin
        fwd_en[r] = 1'b1;
        fwd_data[r] = bus.wr1_data;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      q_count <= '0;
      bus.rf_wr_en <= 1'b0;
      bus.rf_wr_addr <= '0;
      bus.rf_wr_data <= '0;
      bus.rd_fwd_en <= '0;
      bus.rd_fwd_data <= '0;
      bus.ovf_err <= 1'b0;
    end else begin
      bus.rf_wr_en <= ld_en;
      bus.rf_wr_addr <= ld_addr;
      bus.rf_wr_data <= ld_data;
      if (n_push != '0) begin
        q_addr[tail] <= p0_addr;
        q_data[tail] <= p0_data;
      end
      if (n_push == CW'(2)) begin
        q_addr[tail + PW'(1)] <= bus.wr1_addr;
        q_data[tail + PW'(1)] <= bus.wr1_data;
      end
      tail <= tail + PW'(n_push);
      head <= head + PW'(pop);
      q_count <= q_count + n_push - CW'(pop);
      bus.ovf_err <= bus.ovf_err | (bus.wr_stall & (bus.wr0_en | bus.wr1_en));
      bus.rd_fwd_en <= fwd_en;
      bus.rd_fwd_data <= fwd_data;
    end
  end
endmodule

// File: tb/tb_reg_wr_sched_fpga.sv
// tb_reg_wr_sched_fpga: directed vectors with hand-computed expectations for reg_wr_sched_fpga
module tb_reg_wr_sched_fpga;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  reg_wr_sched_if #(.QDEPTH(4), .ADDR_W(7), .DATA_W(32)) bus ();
  reg_wr_sched_fpga #(.QDEPTH(4), .ADDR_W(7), .DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic e0, input logic [6:0] a0, input logic [31:0] d0,
                    input logic e1, input logic [6:0] a1, input logic [31:0] d1);
    bus.wr0_en = e0; bus.wr0_addr = a0; bus.wr0_data = d0;
    bus.wr1_en = e1; bus.wr1_addr = a1; bus.wr1_data = d1;
  endtask
  task automatic rf(input string tag, input logic en, input logic [6:0] a, input logic [31:0] d);
    chk({tag, "_en"}, 32'(bus.rf_wr_en), 32'(en));
    if (en) begin
      chk({tag, "_addr"}, 32'(bus.rf_wr_addr), 32'(a));
      chk({tag, "_data"}, bus.rf_wr_data, d);
    end
  endtask
  initial begin
    wr(0, 0, 0, 0, 0, 0);
    bus.rd_addr[0] = 7'd120; bus.rd_addr[1] = 7'd121; bus.rd_addr[2] = 7'd122;
    tick(); tick();
    chk("rst_rf_en", 32'(bus.rf_wr_en), 0);
    chk("rst_qcnt", 32'(bus.q_count), 0);
    chk("rst_stall", 32'(bus.wr_stall), 0);
    chk("rst_ovf", 32'(bus.ovf_err), 0);
    chk("rst_fwd_en", 32'(bus.rd_fwd_en), 0);
    rst = 1'b0;
    // lone write
    wr(1, 5, 32'hA5A5A5A5, 0, 0, 0);
    tick();
    rf("t1", 1, 5, 32'hA5A5A5A5);
    chk("t1_qcnt", 32'(bus.q_count), 0);
    wr(0, 0, 0, 0, 0, 0);
    tick();
    rf("t1_idle", 0, 0, 0);
    // dual write same address, then forwarded read of the queued one
    wr(1, 3, 32'h11, 1, 3, 32'h22);
    tick();
    rf("t2_n1", 1, 3, 32'h11);
    chk("t2_qcnt", 32'(bus.q_count), 1);
    wr(0, 0, 0, 0, 0, 0);
    bus.rd_addr[0] = 7'd3;
    tick();
    rf("t2_n2", 1, 3, 32'h22);
    chk("t2_fwd_en", 32'(bus.rd_fwd_en[0]), 1);
    chk("t2_fwd_data", bus.rd_fwd_data[0], 32'h22);
    bus.rd_addr[0] = 7'd120;
    // fill to stall
    wr(1, 10, 32'hA0, 1, 11, 32'hA1);
    tick();
    chk("t3_q1", 32'(bus.q_count), 1);
    chk("t3_stall1", 32'(bus.wr_stall), 0);
    rf("t3_d0", 1, 10, 32'hA0);
    wr(1, 12, 32'hA2, 1, 13, 32'hA3);
    tick();
    chk("t3_q2", 32'(bus.q_count), 2);
    chk("t3_stall2", 32'(bus.wr_stall), 0);
    rf("t3_d1", 1, 11, 32'hA1);
    wr(1, 14, 32'hA4, 1, 15, 32'hA5);
    tick();
    chk("t3_q3", 32'(bus.q_count), 3);
    chk("t3_stall3", 32'(bus.wr_stall), 1);
    chk("t3_ovf", 32'(bus.ovf_err), 0);
    rf("t3_d2", 1, 12, 32'hA2);
    // write while stalled is dropped
    wr(1, 50, 32'hBAD, 0, 0, 0);
    tick();
    chk("t4_ovf", 32'(bus.ovf_err), 1);
    chk("t4_q", 32'(bus.q_count), 2);
    rf("t4_d3", 1, 13, 32'hA3);
    wr(0, 0, 0, 0, 0, 0);
    tick();
    rf("t4_d4", 1, 14, 32'hA4);
    tick();
    rf("t4_d5", 1, 15, 32'hA5);
    chk("t4_q0", 32'(bus.q_count), 0);
    tick();
    rf("t4_empty", 0, 0, 0);
    chk("t4_ovf_sticky", 32'(bus.ovf_err), 1);
    // queue beats rf register; wr0 input beats rf register
    wr(1, 9, 32'h66, 1, 9, 32'h77);
    tick();
    wr(0, 0, 0, 0, 0, 0);
    bus.rd_addr[1] = 7'd9;
    tick();
    chk("t5_fwd1_en", 32'(bus.rd_fwd_en[1]), 1);
    chk("t5_fwd1_data", bus.rd_fwd_data[1], 32'h77);
    chk("t5_fwd0_en", 32'(bus.rd_fwd_en[0]), 0);
    chk("t5_fwd0_data", bus.rd_fwd_data[0], 0);
    chk("t5_fwd2_en", 32'(bus.rd_fwd_en[2]), 0);
    bus.rd_addr[1] = 7'd121;
    bus.rd_addr[2] = 7'd9;
    wr(1, 9, 32'h88, 0, 0, 0);
    tick();
    chk("t5_wr0_fwd_en", 32'(bus.rd_fwd_en[2]), 1);
    chk("t5_wr0_fwd_data", bus.rd_fwd_data[2], 32'h88);
    chk("t5_fwd1_off", 32'(bus.rd_fwd_en[1]), 0);
    wr(0, 0, 0, 0, 0, 0);
    bus.rd_addr[2] = 7'd122;
    tick();
    tick();
    // reset with three entries pending
    wr(1, 20, 32'hC0, 1, 21, 32'hC1);
    tick();
    wr(1, 22, 32'hC2, 1, 23, 32'hC3);
    tick();
    wr(1, 24, 32'hC4, 1, 25, 32'hC5);
    tick();
    chk("t6_q3", 32'(bus.q_count), 3);
    wr(0, 0, 0, 0, 0, 0);
    bus.rd_addr[0] = 7'd25;
    rst = 1'b1;
    tick();
    chk("t6_q0", 32'(bus.q_count), 0);
    chk("t6_rf_en", 32'(bus.rf_wr_en), 0);
    chk("t6_fwd_en", 32'(bus.rd_fwd_en), 0);
    chk("t6_ovf", 32'(bus.ovf_err), 0);
    chk("t6_stall", 32'(bus.wr_stall), 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_no_drain", 32'(bus.rf_wr_en), 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
